// File: rtl/spi_slave_ram_top.sv
// spi_slave_ram_top: SPI-style slave front end in the system clock domain
// driving a 256 x 8 single-port RAM. Command frames are 10 bits MSB-first
// on MOSI while SS_n is low; read data is returned MSB-first on MISO.

// ---------------------------------------------------------------------------
// Serial slave: frame capture, command dispatch and MISO shift-out.
// ---------------------------------------------------------------------------
module spi_slave_core #(
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_ss_n,
   input  logic                 i_mosi,
   output logic                 o_miso,
   output logic [ADDR_SIZE+1:0] o_rx_data,
   output logic                 o_rx_valid,
   input  logic [ADDR_SIZE-1:0] i_tx_data,
   input  logic                 i_tx_valid
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHK_CMD,
      ST_WRITE,
      ST_READ_ADD,
      ST_READ_DATA
   } slave_state_e;

   localparam int FRAME_BITS = ADDR_SIZE + 2;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   // Bit counter values: frame is complete once the last bit is shifted in.
   localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_BITS - 1);
   // Shift-out counter: 0 waiting for tx_valid, 1..ADDR_SIZE-1 shifting,
   // ADDR_SIZE last bit on the wire, ADDR_SIZE+1 burst finished.
   localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(ADDR_SIZE);
   localparam logic [CNT_W-1:0] TX_DONE   = CNT_W'(ADDR_SIZE + 1);

   slave_state_e          r_state;
   slave_state_e          w_next_state;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [CNT_W-1:0]      r_tx_cnt;
   logic [ADDR_SIZE+1:0]  r_rx_data;
   logic                  r_rx_valid;
   logic                  r_rd_addr_flag;
   logic                  r_miso;
   logic [ADDR_SIZE-1:0]  r_tx_shift;
   logic                  w_in_frame;

   assign w_in_frame = (r_state == ST_WRITE) || (r_state == ST_READ_ADD) ||
                       (r_state == ST_READ_DATA);

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state decode: SS_n high always returns to IDLE.
   always_comb begin
      // NOTE: default first so no path through the case leaves the output
      // unassigned, which would otherwise infer a latch.
      w_next_state = r_state;
      if (i_ss_n) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    w_next_state = ST_CHK_CMD;
            ST_CHK_CMD: begin
               if (!i_mosi)             w_next_state = ST_WRITE;
               else if (r_rd_addr_flag) w_next_state = ST_READ_DATA;
               else                     w_next_state = ST_READ_ADD;
            end
            default:    w_next_state = r_state;
         endcase
      end
   end

   // Frame shift-in, rx_valid pulse, read-address flag and MISO shift-out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bit_cnt      <= '0;
         r_tx_cnt       <= '0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_rd_addr_flag <= 1'b0;
         r_miso         <= 1'b0;
         r_tx_shift     <= '0;
      end else begin
         r_rx_valid <= 1'b0;
         if (i_ss_n) begin
            // Deselect abandons any partial frame or burst.
            r_bit_cnt <= '0;
            r_tx_cnt  <= '0;
            r_miso    <= 1'b0;
         end else begin
            if (w_in_frame && (r_bit_cnt < FRAME_LEN)) begin
               r_rx_data <= {r_rx_data[ADDR_SIZE:0], i_mosi};
               r_bit_cnt <= r_bit_cnt + 1'b1;
               if (r_bit_cnt == LAST_BIT) begin
                  r_rx_valid <= 1'b1;
                  if (r_state == ST_READ_ADD) r_rd_addr_flag <= 1'b1;
               end
            end
            if (r_state == ST_READ_DATA) begin
               if (r_tx_cnt == '0) begin
                  if (i_tx_valid) begin
                     r_miso     <= i_tx_data[ADDR_SIZE-1];
                     r_tx_shift <= {i_tx_data[ADDR_SIZE-2:0], 1'b0};
                     r_tx_cnt   <= 1'b1;
                  end
               end else if (r_tx_cnt < TX_LAST) begin
                  r_miso     <= r_tx_shift[ADDR_SIZE-1];
                  r_tx_shift <= {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
                  r_tx_cnt   <= r_tx_cnt + 1'b1;
               end else if (r_tx_cnt == TX_LAST) begin
                  r_miso         <= 1'b0;
                  r_tx_cnt       <= TX_DONE;
                  r_rd_addr_flag <= 1'b0;
               end
            end
         end
      end
   end

   assign o_miso     = r_miso;
   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;

endmodule

// ---------------------------------------------------------------------------
// Single-port RAM with command decode on din[top:top-1].
// ---------------------------------------------------------------------------
module spi_ram #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_SIZE+1:0] i_din,
   input  logic                 i_rx_valid,
   output logic [ADDR_SIZE-1:0] o_dout,
   output logic                 o_tx_valid
);

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   logic [ADDR_SIZE-1:0] mem [0:MEM_DEPTH-1];
   logic [ADDR_SIZE-1:0] r_wr_addr;
   logic [ADDR_SIZE-1:0] r_rd_addr;
   logic [ADDR_SIZE-1:0] r_dout;
   logic                 r_tx_valid;
   logic [1:0]           w_op;
   logic [ADDR_SIZE-1:0] w_payload;

   assign w_op      = i_din[ADDR_SIZE+1:ADDR_SIZE];
   assign w_payload = i_din[ADDR_SIZE-1:0];

   // Address registers, read data and the one-cycle tx_valid strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_addr  <= '0;
         r_rd_addr  <= '0;
         r_dout     <= '0;
         r_tx_valid <= 1'b0;
      end else begin
         r_tx_valid <= 1'b0;
         if (i_rx_valid) begin
            case (w_op)
               OP_WR_ADDR: r_wr_addr <= w_payload;
               OP_RD_ADDR: r_rd_addr <= w_payload;
               OP_RD_DATA: begin
                  r_dout     <= mem[r_rd_addr];
                  r_tx_valid <= 1'b1;
               end
               default:    ;
            endcase
         end
      end
   end

   // Array write port; reset only blocks the write, it never clears contents.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset branch, so it maps onto plain
      // RAM and keeps preloaded contents across rst_n.
      if (rst_n && i_rx_valid && (w_op == OP_WR_DATA))
         mem[r_wr_addr] <= w_payload;
   end

   assign o_dout     = r_dout;
   assign o_tx_valid = r_tx_valid;

endmodule

// ---------------------------------------------------------------------------
// Top level: slave front end plus the RAM instance named RAM.
// ---------------------------------------------------------------------------
module spi_slave_ram_top #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic MOSI,
   output logic MISO,
   input  logic SS_n
);

   logic [ADDR_SIZE+1:0] w_rx_data;
   logic                 w_rx_valid;
   logic [ADDR_SIZE-1:0] w_dout;
   logic                 w_tx_valid;

   spi_slave_core #(
      .ADDR_SIZE (ADDR_SIZE)
   ) u_slave (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_ss_n     (SS_n),
      .i_mosi     (MOSI),
      .o_miso     (MISO),
      .o_rx_data  (w_rx_data),
      .o_rx_valid (w_rx_valid),
      .i_tx_data  (w_dout),
      .i_tx_valid (w_tx_valid)
   );

   spi_ram #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) RAM (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_din      (w_rx_data),
      .i_rx_valid (w_rx_valid),
      .o_dout     (w_dout),
      .o_tx_valid (w_tx_valid)
   );

endmodule

// File: tb/tb_spi_slave_ram_top.sv
// Bench for spi_slave_ram_top: frame-level reference model (memory array,
// address registers, read-address flag) predicts MISO every cycle of every
// frame, plus RAM contents and control registers after each frame.
module tb_spi_slave_ram_top;

   localparam int MEM_DEPTH = 256;
   localparam int ADDR_SIZE = 8;
   localparam int FULL      = 99;   // cut value meaning "no abort"
   localparam int LAST_EDGE = 23;   // edges observed per frame with SS_n low

   logic clk = 1'b0;
   logic rst_n;
   logic MOSI;
   logic SS_n;
   logic MISO;

   always #5 clk = ~clk;

   spi_slave_ram_top #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .MOSI  (MOSI),
      .MISO  (MISO),
      .SS_n  (SS_n)
   );

   // Reference model state
   logic [7:0] m_mem [MEM_DEPTH];
   logic [7:0] m_wr_addr;
   logic [7:0] m_rd_addr;
   logic       m_flag;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, " wr_addr"}, 32'(dut.RAM.r_wr_addr), 32'(m_wr_addr));
      check({tag, " rd_addr"}, 32'(dut.RAM.r_rd_addr), 32'(m_rd_addr));
      check({tag, " rd_flag"}, 32'(dut.u_slave.r_rd_addr_flag), 32'(m_flag));
   endtask

   task automatic check_mem_all(input string tag);
      for (int i = 0; i < MEM_DEPTH; i++)
         check($sformatf("%s mem[%0d]", tag, i), 32'(dut.RAM.mem[i]),
               32'(m_mem[i]));
   endtask

   // One frame: cmd bit then 10 frame bits; SS_n is held low for edges
   // 1..cut (cut >= 12 completes the frame) then raised for one cycle.
   task automatic run_frame(input logic cmd, input logic [9:0] frame,
                            input int cut);
      int         kind;     // 0 write, 1 read-address, 2 read-data
      int         last;
      logic [1:0] op;
      logic [7:0] rd_byte;
      logic       exp_miso;
      kind    = (cmd == 1'b0) ? 0 : (m_flag ? 2 : 1);
      op      = frame[9:8];
      rd_byte = m_mem[m_rd_addr];
      last    = (cut < LAST_EDGE) ? cut : LAST_EDGE;

      @(negedge clk);
      SS_n = 1'b0;
      MOSI = 1'($urandom);
      for (int e = 1; e <= last; e++) begin
         @(negedge clk);
         exp_miso = 1'b0;
         if (kind == 2 && op == 2'b11 && e >= 14 && e <= 21)
            exp_miso = rd_byte[21 - e];
         check($sformatf("miso e%0d cmd%0b f%03h", e, cmd, frame),
               32'(MISO), 32'(exp_miso));
         if (e < last) begin
            if (e + 1 == 2)                    MOSI = cmd;
            else if (e + 1 >= 3 && e + 1 <= 12) MOSI = frame[12 - (e + 1)];
            else                               MOSI = 1'($urandom);
         end
      end
      SS_n = 1'b1;
      MOSI = 1'($urandom);
      @(negedge clk);
      check("miso after ss_n high", 32'(MISO), 32'd0);

      if (cut >= 12) begin
         case (op)
            2'b00: m_wr_addr = frame[7:0];
            2'b01: m_mem[m_wr_addr] = frame[7:0];
            2'b10: m_rd_addr = frame[7:0];
            default: ;
         endcase
         if (kind == 1) m_flag = 1'b1;
      end
      if (kind == 2 && op == 2'b11 && cut >= 22) m_flag = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      SS_n  = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_wr_addr = '0;
      m_rd_addr = '0;
      m_flag    = 1'b0;
   endtask

   // Guard against a stalled run.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       cmd;
      logic [1:0] op;
      logic [7:0] val;
      int         cut;

      rst_n = 1'b0;
      SS_n  = 1'b1;
      MOSI  = 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 'x;
      m_wr_addr = '0;
      m_rd_addr = '0;
      m_flag    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("reset miso", 32'(MISO), 32'd0);
      check("reset tx_valid", 32'(dut.RAM.r_tx_valid), 32'd0);
      check_regs("reset");

      // Preload every word through the serial port.
      for (int a = 0; a < MEM_DEPTH; a++) begin
         val = 8'($urandom);
         run_frame(1'b0, {2'b00, 8'(a)}, FULL);
         run_frame(1'b0, {2'b01, val}, FULL);
      end
      check_mem_all("preload");

      // Reset with the read-address flag set: registers clear, memory kept.
      run_frame(1'b1, 10'b10_01010101, FULL);
      check_regs("flag set");
      do_reset();
      check("reset2 miso", 32'(MISO), 32'd0);
      check("reset2 tx_valid", 32'(dut.RAM.r_tx_valid), 32'd0);
      check_regs("reset2");
      check_mem_all("after reset");

      // Directed write / read sequence.
      run_frame(1'b0, 10'b00_00000011, FULL);
      check_regs("wr addr 3");
      run_frame(1'b0, 10'b01_11110000, FULL);
      check("mem[3]", 32'(dut.RAM.mem[3]), 32'h0F0);
      check_mem_all("wr data");
      run_frame(1'b1, 10'b10_00000011, FULL);
      check_regs("rd addr 3");
      run_frame(1'b1, 10'b11_00000000, FULL);
      check_regs("rd data 3");
      run_frame(1'b1, 10'b10_00000111, FULL);
      check_regs("cmd1 after read");

      // Abort a data write after 5 frame bits, then a normal frame.
      run_frame(1'b0, 10'b00_00000111, FULL);
      run_frame(1'b0, 10'b01_10101010, 7);
      check_mem_all("abort");
      check_regs("abort");
      run_frame(1'b0, 10'b01_00111100, FULL);
      check("mem[7]", 32'(dut.RAM.mem[7]), 32'h03C);
      run_frame(1'b1, 10'b11_00000000, FULL);   // flag still set -> read
      check_regs("read 7");

      // Abort mid-burst keeps the flag; next read repeats the burst.
      run_frame(1'b1, 10'b10_11111111, FULL);
      run_frame(1'b1, 10'b11_00000000, 17);
      check_regs("burst abort");
      run_frame(1'b1, 10'b11_00000000, FULL);
      check_regs("burst retry");

      // Highest and lowest addresses.
      run_frame(1'b0, 10'b00_11111111, FULL);
      run_frame(1'b0, 10'b01_10000001, FULL);
      run_frame(1'b0, 10'b00_00000000, FULL);
      run_frame(1'b0, 10'b01_01111110, FULL);
      run_frame(1'b1, 10'b10_11111111, FULL);
      run_frame(1'b1, 10'b11_00000000, FULL);
      run_frame(1'b1, 10'b10_00000000, FULL);
      run_frame(1'b1, 10'b11_00000000, FULL);
      check_regs("boundary");

      // Randomized frames with occasional aborts.
      for (int n = 0; n < 300; n++) begin
         cmd = 1'($urandom);
         op  = 2'($urandom);
         if (cmd && m_flag && ($urandom_range(0, 3) != 0)) op = 2'b11;
         val = 8'($urandom_range(0, 15));   // small range revisits addresses
         if ($urandom_range(0, 1) == 0) val = 8'($urandom);
         cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 22)) : FULL;
         run_frame(cmd, {op, val}, cut);
         check_regs("random");
      end
      check_mem_all("final");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
